// File: rtl/difftest_commit_buffer_if.sv
// Retire-side and commit-side bundles for the difftest commit buffer.
// The retire bundle is a valid/ready handshake; the commit bundle is the difftest packet.
interface difftest_retire_if;
   logic        retire_valid;
   logic        retire_ready;
   logic [63:0] retire_pc;
   logic [31:0] retire_instr;
   logic        retire_rfwen;
   logic [4:0]  retire_wdest;
   logic        retire_mmio;
   logic        retire_load;
   logic        retire_store;

   modport master (
      output retire_valid, retire_pc, retire_instr, retire_rfwen,
             retire_wdest, retire_mmio, retire_load, retire_store,
      input  retire_ready
   );
   modport slave (
      input  retire_valid, retire_pc, retire_instr, retire_rfwen,
             retire_wdest, retire_mmio, retire_load, retire_store,
      output retire_ready
   );
endinterface

interface difftest_commit_if;
   logic        drain_en;
   logic        commit_valid;
   logic        commit_skip;
   logic        commit_isRVC;
   logic        commit_rfwen;
   logic        commit_isLoad;
   logic        commit_isStore;
   logic [7:0]  commit_wdest;
   logic [4:0]  commit_wpdest;
   logic [63:0] commit_pc;
   logic [31:0] commit_instr;
   logic [9:0]  commit_robIdx;
   logic [7:0]  commit_index;
   logic [7:0]  commit_coreid;
   logic [7:0]  commit_nFused;
   logic [7:0]  commit_special;
   logic        commit_fpwen;
   logic        commit_vecwen;
   logic [6:0]  commit_lqIdx;
   logic [6:0]  commit_sqIdx;
   logic        trap_valid;
   logic [63:0] instret;

   modport master (
      input  drain_en,
      output commit_valid, commit_skip, commit_isRVC, commit_rfwen,
             commit_isLoad, commit_isStore, commit_wdest, commit_wpdest,
             commit_pc, commit_instr, commit_robIdx, commit_index,
             commit_coreid, commit_nFused, commit_special, commit_fpwen,
             commit_vecwen, commit_lqIdx, commit_sqIdx, trap_valid, instret
   );
   modport slave (
      output drain_en,
      input  commit_valid, commit_skip, commit_isRVC, commit_rfwen,
             commit_isLoad, commit_isStore, commit_wdest, commit_wpdest,
             commit_pc, commit_instr, commit_robIdx, commit_index,
             commit_coreid, commit_nFused, commit_special, commit_fpwen,
             commit_vecwen, commit_lqIdx, commit_sqIdx, trap_valid, instret
   );
endinterface

// File: rtl/difftest_commit_buffer.sv
// Buffers retired instructions and emits registered difftest commit packets.
// An emitted ebreak halts the buffer until reset.
module difftest_commit_buffer #(
   parameter int unsigned DEPTH  = 4,
   parameter logic [7:0]  COREID = 8'h00
) (
   input  logic              clock,
   input  logic              rst_n,
   difftest_retire_if.slave  retire_i,
   difftest_commit_if.master commit_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        rfwen;
      logic [4:0]  wdest;
      logic        mmio;
      logic        load;
      logic        store;
   } entry_t;

   entry_t        mem_q [DEPTH];
   entry_t        head;
   entry_t        wentry;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          halted_q, halted_d;
   logic [63:0]   instret_q, instret_d;
   logic          ready, push, pop, is_trap;

   logic          valid_q, trap_q;
   logic [63:0]   pc_q;
   logic [31:0]   instr_q;
   logic          skip_q, rvc_q, rfwen_q, load_q, store_q;
   logic [4:0]    wdest_q;
   logic [9:0]    rob_q;
   logic [7:0]    idx_q;

   assign head    = mem_q[rptr_q];
   assign is_trap = (head.instr == EBREAK);
   assign wentry  = '{
      pc:    retire_i.retire_pc,
      instr: retire_i.retire_instr,
      rfwen: retire_i.retire_rfwen,
      wdest: retire_i.retire_wdest,
      mmio:  retire_i.retire_mmio,
      load:  retire_i.retire_load,
      store: retire_i.retire_store
   };

   always_comb begin
      ready     = (cnt_q != FULL_CNT) && !halted_q;
      push      = retire_i.retire_valid && ready;
      pop       = (cnt_q != '0) && commit_o.drain_en && !halted_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      cnt_d     = cnt_q;
      halted_d  = halted_q;
      instret_d = instret_q;
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop) begin
         rptr_d    = rptr_q + 1'b1;
         instret_d = instret_q + 64'd1;
         halted_d  = halted_q | is_trap;
      end
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
   end

   // Storage needs no reset: only slots behind the write pointer are read.
   always_ff @(posedge clock) begin
      if (push) mem_q[wptr_q] <= wentry;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         cnt_q     <= '0;
         halted_q  <= 1'b0;
         instret_q <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         cnt_q     <= cnt_d;
         halted_q  <= halted_d;
         instret_q <= instret_d;
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         trap_q  <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
         skip_q  <= 1'b0;
         rvc_q   <= 1'b0;
         rfwen_q <= 1'b0;
         load_q  <= 1'b0;
         store_q <= 1'b0;
         wdest_q <= '0;
         rob_q   <= '0;
         idx_q   <= '0;
      end else begin
         valid_q <= pop;
         trap_q  <= pop && is_trap;
         if (pop) begin
            pc_q    <= head.pc;
            instr_q <= head.instr;
            skip_q  <= head.mmio;
            rvc_q   <= (head.instr[1:0] != 2'b11);
            rfwen_q <= head.rfwen;
            load_q  <= head.load;
            store_q <= head.store;
            wdest_q <= head.wdest;
            rob_q   <= instret_q[9:0];
            idx_q   <= instret_q[7:0];
         end
      end
   end

   assign retire_i.retire_ready   = ready;
   assign commit_o.commit_valid   = valid_q;
   assign commit_o.trap_valid     = trap_q;
   assign commit_o.instret        = instret_q;
   assign commit_o.commit_pc      = pc_q;
   assign commit_o.commit_instr   = instr_q;
   assign commit_o.commit_skip    = skip_q;
   assign commit_o.commit_isRVC   = rvc_q;
   assign commit_o.commit_rfwen   = rfwen_q;
   assign commit_o.commit_isLoad  = load_q;
   assign commit_o.commit_isStore = store_q;
   assign commit_o.commit_wdest   = {3'b000, wdest_q};
   assign commit_o.commit_wpdest  = wdest_q;
   assign commit_o.commit_robIdx  = rob_q;
   assign commit_o.commit_index   = idx_q;
   assign commit_o.commit_coreid  = COREID;
   assign commit_o.commit_nFused  = '0;
   assign commit_o.commit_special = '0;
   assign commit_o.commit_fpwen   = 1'b0;
   assign commit_o.commit_vecwen  = 1'b0;
   assign commit_o.commit_lqIdx   = '0;
   assign commit_o.commit_sqIdx   = '0;
endmodule

// File: tb/tb_difftest_commit_buffer.sv
// Randomized and directed bench for difftest_commit_buffer against a queue model.
// Directed phases pin the model with hand-computed literals.
module tb_difftest_commit_buffer;
   localparam int DEPTH = 4;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   logic clock = 1'b0;
   logic rst_n = 1'b0;
   always #5 clock = ~clock;

   difftest_retire_if rif ();
   difftest_commit_if cif ();

   difftest_commit_buffer #(.DEPTH(DEPTH), .COREID(8'h00)) dut (
      .clock    (clock),
      .rst_n    (rst_n),
      .retire_i (rif),
      .commit_o (cif)
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        rfwen;
      logic [4:0]  wdest;
      logic        mmio;
      logic        load;
      logic        store;
   } ent_t;

   ent_t        mq[$];
   logic [63:0] m_instret;
   bit          m_halt, m_pushed;
   logic        e_valid, e_trap, e_skip, e_rvc, e_rfwen, e_ld, e_st;
   logic [63:0] e_pc;
   logic [31:0] e_instr;
   logic [4:0]  e_wdest;
   logic [9:0]  e_rob;
   logic [7:0]  e_idx;
   int          n_pass = 0;
   int          n_total = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %0h want %0h", nm, act, exp);
      else n_pass++;
   endtask

   task automatic m_reset();
      mq.delete();
      m_instret = '0;
      m_halt = 0;
      m_pushed = 0;
      e_valid = 0; e_trap = 0; e_skip = 0; e_rvc = 0;
      e_rfwen = 0; e_ld = 0; e_st = 0;
      e_pc = '0; e_instr = '0; e_wdest = '0; e_rob = '0; e_idx = '0;
   endtask

   // Behaviour of one clock edge, using the inputs as they stood before it.
   task automatic model_edge();
      bit   rdy, pop;
      ent_t in, e;
      rdy = (mq.size() < DEPTH) && !m_halt;
      pop = (mq.size() > 0) && cif.drain_en && !m_halt;
      in.pc = rif.retire_pc;       in.instr = rif.retire_instr;
      in.rfwen = rif.retire_rfwen; in.wdest = rif.retire_wdest;
      in.mmio = rif.retire_mmio;   in.load = rif.retire_load;
      in.store = rif.retire_store;
      m_pushed = rif.retire_valid && rdy;
      e_valid = 0;
      e_trap = 0;
      if (pop) begin
         e = mq.pop_front();
         e_valid = 1;
         e_pc = e.pc; e_instr = e.instr; e_rfwen = e.rfwen;
         e_wdest = e.wdest; e_ld = e.load; e_st = e.store;
         e_skip = e.mmio;
         e_rvc = (e.instr[1:0] != 2'b11);
         e_rob = m_instret[9:0];
         e_idx = m_instret[7:0];
         m_instret = m_instret + 1;
         if (e.instr == EBREAK) begin
            e_trap = 1;
            m_halt = 1;
         end
      end
      if (m_pushed) mq.push_back(in);
   endtask

   task automatic compare();
      chk("ready", rif.retire_ready, (mq.size() < DEPTH) && !m_halt);
      chk("valid", cif.commit_valid, e_valid);
      chk("trap", cif.trap_valid, e_trap);
      chk("instret", cif.instret, m_instret);
      chk("pc", cif.commit_pc, e_pc);
      chk("instr", cif.commit_instr, e_instr);
      chk("skip", cif.commit_skip, e_skip);
      chk("isRVC", cif.commit_isRVC, e_rvc);
      chk("rfwen", cif.commit_rfwen, e_rfwen);
      chk("isLoad", cif.commit_isLoad, e_ld);
      chk("isStore", cif.commit_isStore, e_st);
      chk("wdest", cif.commit_wdest, {3'b000, e_wdest});
      chk("wpdest", cif.commit_wpdest, e_wdest);
      chk("robIdx", cif.commit_robIdx, e_rob);
      chk("index", cif.commit_index, e_idx);
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      compare();
   endtask

   task automatic do_reset();
      rif.retire_valid = 0;
      cif.drain_en = 0;
      #2;
      rst_n = 0;
      #1;
      chk("rst_valid", cif.commit_valid, 0);
      chk("rst_trap", cif.trap_valid, 0);
      chk("rst_instret", cif.instret, 0);
      chk("rst_pc", cif.commit_pc, 0);
      chk("rst_instr", cif.commit_instr, 0);
      chk("rst_index", cif.commit_index, 0);
      chk("rst_isRVC", cif.commit_isRVC, 0);
      chk("rst_wdest", cif.commit_wdest, 0);
      chk("rst_coreid", cif.commit_coreid, 0);
      chk("rst_nFused", cif.commit_nFused, 0);
      m_reset();
      @(negedge clock);
      rst_n = 1;
      #1;
      chk("rst_ready", rif.retire_ready, 1);
   endtask

   task automatic rand_fields();
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(1) == 1) ins[1:0] = 2'b11;
      if (ins == EBREAK) ins = 32'h0000_0013;
      rif.retire_pc    = {$urandom, $urandom};
      rif.retire_instr = ins;
      rif.retire_rfwen = 1'($urandom);
      rif.retire_wdest = 5'($urandom);
      rif.retire_mmio  = 1'($urandom);
      rif.retire_load  = 1'($urandom);
      rif.retire_store = 1'($urandom);
   endtask

   task automatic retire_one(logic [63:0] pc, logic [31:0] ins,
                             logic mmio, logic [4:0] wd);
      bit ok;
      rif.retire_pc = pc;     rif.retire_instr = ins;
      rif.retire_rfwen = 1;   rif.retire_wdest = wd;
      rif.retire_mmio = mmio; rif.retire_load = 0;
      rif.retire_store = 0;   rif.retire_valid = 1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         step();
         ok = m_pushed;
      end
      rif.retire_valid = 0;
      if (!ok) chk("push_timeout", 0, 1);
   endtask

   task automatic wait_commit(output bit ok);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         step();
         ok = cif.commit_valid;
      end
      if (!ok) chk("commit_timeout", 0, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      bit ok;
      int idxs[$];
      int sent, got, tcnt, cv_after, rdy_after;
      bit seen;
      logic [7:0] last_idx;
      logic [9:0] last_rob;

      rif.retire_pc = '0; rif.retire_instr = '0; rif.retire_rfwen = 0;
      rif.retire_wdest = '0; rif.retire_mmio = 0; rif.retire_load = 0;
      rif.retire_store = 0;
      do_reset();

      // single retire, then compressed mmio instruction
      cif.drain_en = 1;
      retire_one(64'h8000_0000, 32'h0000_0513, 0, 5'd10);
      wait_commit(ok);
      chk("t1_index", cif.commit_index, 8'h00);
      chk("t1_rob", cif.commit_robIdx, 10'h000);
      chk("t1_isRVC", cif.commit_isRVC, 0);
      chk("t1_wdest", cif.commit_wdest, 8'h0A);
      chk("t1_instret", cif.instret, 64'd1);
      chk("t1_pc", cif.commit_pc, 64'h8000_0000);
      retire_one(64'h8000_0004, 32'h0000_4501, 1, 5'd10);
      wait_commit(ok);
      chk("t2_isRVC", cif.commit_isRVC, 1);
      chk("t2_skip", cif.commit_skip, 1);
      chk("t2_index", cif.commit_index, 8'h01);

      // fill with drain disabled, then release
      do_reset();
      for (int k = 0; k < 4; k++) retire_one(64'h1000 + 64'(4 * k), 32'h13, 0, 5'(k));
      chk("t3_ready_full", rif.retire_ready, 0);
      rif.retire_pc = 64'h1010;
      rif.retire_valid = 1;
      cif.drain_en = 1;
      idxs.delete();
      for (int c = 0; c < 10; c++) begin
         step();
         if (m_pushed) rif.retire_valid = 0;
         if (cif.commit_valid) idxs.push_back(int'(cif.commit_index));
      end
      chk("t3_npkts", idxs.size(), 5);
      for (int k = 0; k < 5; k++)
         if (k < idxs.size()) chk("t3_idx", idxs[k], k);

      // 257 commits: index wraps, robIdx keeps counting
      do_reset();
      cif.drain_en = 1;
      sent = 0; got = 0; last_idx = '0; last_rob = '0;
      for (int c = 0; c < 3000 && got < 257; c++) begin
         if (sent < 257) begin
            rand_fields();
            rif.retire_valid = 1;
         end else rif.retire_valid = 0;
         step();
         if (m_pushed) sent++;
         if (cif.commit_valid) begin
            got++;
            last_idx = cif.commit_index;
            last_rob = cif.commit_robIdx;
         end
      end
      rif.retire_valid = 0;
      chk("t4_got", got, 257);
      chk("t4_instret", cif.instret, 64'd257);
      chk("t4_last_idx", last_idx, 8'h00);
      chk("t4_last_rob", last_rob, 10'h100);

      // ebreak halts the buffer
      do_reset();
      cif.drain_en = 1;
      retire_one(64'h8000_0100, EBREAK, 0, 5'd0);
      rif.retire_instr = 32'h0000_0093;
      rif.retire_valid = 1;
      tcnt = 0; cv_after = 0; rdy_after = 0; seen = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if (seen && cif.commit_valid) cv_after++;
         if (cif.trap_valid) begin
            tcnt++;
            seen = 1;
            chk("t5_trap_pc", cif.commit_pc, 64'h8000_0100);
         end
         if (seen && rif.retire_ready) rdy_after++;
      end
      rif.retire_valid = 0;
      chk("t5_trap_cnt", tcnt, 1);
      chk("t5_cv_after", cv_after, 0);
      chk("t5_rdy_after", rdy_after, 0);
      chk("t5_instret", cif.instret, 64'd1);

      // reset with entries buffered
      do_reset();
      cif.drain_en = 1;
      retire_one(64'h2000, 32'h13, 0, 5'd3);
      wait_commit(ok);
      cif.drain_en = 0;
      for (int k = 0; k < 3; k++) retire_one(64'h3000 + 64'(4 * k), 32'h13, 0, 5'd4);
      do_reset();
      cif.drain_en = 1;
      step();
      step();
      chk("t6_empty", cif.commit_valid, 0);
      retire_one(64'h4000, 32'h0000_0513, 0, 5'd10);
      wait_commit(ok);
      chk("t6_index", cif.commit_index, 8'h00);
      chk("t6_instret", cif.instret, 64'd1);
      chk("t6_pc", cif.commit_pc, 64'h4000);

      // randomized traffic
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         rand_fields();
         rif.retire_valid = ($urandom_range(9) < 6);
         cif.drain_en = ($urandom_range(9) < 6);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/difftest_commit_buffer.md
DIFFTEST_COMMIT_BUFFER -- requirements
Module: difftest_commit_buffer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 Parameter COREID, default 8'h00, constant driven on commit_coreid.
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 retire_valid  in  1  core retires one instruction this cycle.
REQ-006 retire_ready  out  1  buffer accepts; transfer when valid&ready.
REQ-007 retire_pc  in  64  PC of retired instruction.
REQ-008 retire_instr  in  32  raw encoding (compressed in [15:0]).
REQ-009 retire_rfwen  in  1  integer register write.
REQ-010 retire_wdest  in  5  destination register index.
REQ-011 retire_mmio  in  1  instruction accessed MMIO (skip in difftest).
REQ-012 retire_load / retire_store  in  1 each  memory-op class.
REQ-013 drain_en  in  1  consumer enable; 0 holds entries in buffer.
REQ-014 commit_valid  out  1  one commit packet presented this cycle.
REQ-015 commit_skip, commit_isRVC, commit_rfwen, commit_isLoad, commit_isStore  out  1 each  packet flags.
REQ-016 commit_wdest  out  8  {3'b0, wdest}; commit_wpdest out 5 = wdest.
REQ-017 commit_pc  out  64; commit_instr  out  32.
REQ-018 commit_robIdx  out  10  instret[9:0] at time of emission.
REQ-019 commit_index  out  8  running commit sequence number.
REQ-020 commit_coreid  out  8; commit_nFused, commit_special  out  8 each, tied 0; commit_fpwen, commit_vecwen  out  1, tied 0; commit_lqIdx, commit_sqIdx  out  7, tied 0.
REQ-021 trap_valid  out  1  one-cycle pulse when ebreak is emitted.
REQ-022 instret  out  64  count of emitted commits.

Function
REQ-023 FIFO of DEPTH entries; entry = {pc, instr, rfwen, wdest, mmio, load, store}.
REQ-024 retire_ready = !full; push when retire_valid & retire_ready.
REQ-025 Pop when !empty & drain_en; at most one pop per cycle.
REQ-026 Outputs registered: commit_* load from FIFO head on the pop edge; commit_valid=1 the cycle after the pop, else 0.
REQ-027 Latency: push at edge N, empty FIFO, drain_en=1 -> commit_valid high in cycle after edge N+1 (one-cycle bubble through storage).
REQ-028 Simultaneous push and pop: both occur; count unchanged; legal when full only if not full at push decision (ready derived from pre-edge count, so no push when full).
REQ-029 commit_isRVC = (instr[1:0] != 2'b11); commit_skip = mmio.
REQ-030 commit_index increments by 1 per pop, wraps 8'hFF -> 8'h00; first packet after reset carries 0.
REQ-031 instret increments by 1 per pop, 64-bit wrap; commit_robIdx = instret value before increment.
REQ-032 trap_valid=1 in same cycle as commit_valid when commit_instr == 32'h0010_0073; else 0.
REQ-033 After a trap pop, drain stops (sticky halted flag); retire_ready forced 0; cleared only by reset.
REQ-034 Read/write pointers log2(DEPTH) bits plus count register 0..DEPTH; pointers wrap modulo DEPTH.
REQ-035 retire_* fields ignored when not transferring; commit_* fields hold last value when commit_valid=0.

Reset
REQ-036 rst_n low asynchronously clears pointers, count, halted, commit_index, instret, commit_valid, trap_valid, and all commit_* data to 0.
REQ-037 Reset mid-operation discards all buffered entries; retire_ready=1 from first cycle after rst_n deasserts.

Verification
REQ-038 Single retire pc=0x8000_0000 instr=0x0000_0513, rfwen=1 wdest=10, drain_en=1 -> one commit_valid, index=0, robIdx=0, isRVC=0, wdest=8'h0A, instret=1.
REQ-039 drain_en=0, push 5 instrs -> retire_ready low after 4th; raise drain_en -> 4 packets on consecutive cycles, indices 0..3, then 5th accepted and emitted index 4.
REQ-040 Compressed instr 0x0000_4501 with mmio=1 -> commit_isRVC=1, commit_skip=1.
REQ-041 Emit 257 instrs -> indices 0..255,0; instret=257; robIdx of last = 256 (10'h100).
REQ-042 Retire 0x0010_0073 followed by 2 more -> trap_valid pulse with that packet, no further commit_valid, retire_ready stays 0.
REQ-043 Assert rst_n low with 3 entries buffered -> all outputs 0 immediately; after release, empty FIFO, next packet index 0.
